// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port data-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way winner selection: a sole requester wins; on a conflict, either
// fixed CPU priority or the port that did not win last time.
module arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       fixed_prio,
   output logic       winner
);

   always_comb begin
      winner = PORT_CPU;
      unique case (req)
         2'b01:   winner = PORT_CPU;
         2'b10:   winner = PORT_AUX;
         2'b11:   winner = fixed_prio ? PORT_CPU : ~last;
         default: winner = PORT_CPU;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU and auxiliary master accesses onto one data-memory port,
// with programmable wait states and a one-cycle ack per transaction.
//
// state  | meaning
// IDLE   | strobes low, sample requests and pick a winner
// ACCESS | memory strobed from latched fields for WAIT_STATES+1 cycles
// RESP   | ack pulse to the winner, then back to IDLE
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_STATES  = 1,
   parameter int CPU_PRIORITY = 0,
   parameter int DATA_W       = 32
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iReq0,
   input  logic              iReq1,
   input  logic              iWe0,
   input  logic              iWe1,
   input  logic [DATA_W-1:0] iAddr0,
   input  logic [DATA_W-1:0] iAddr1,
   input  logic [DATA_W-1:0] iWdata0,
   input  logic [DATA_W-1:0] iWdata1,
   input  logic [3:0]        iBe0,
   input  logic [3:0]        iBe1,
   output logic              oAck0,
   output logic              oAck1,
   output logic [DATA_W-1:0] oRdata0,
   output logic [DATA_W-1:0] oRdata1,
   output logic              oMemRe,
   output logic              oMemWe,
   output logic [3:0]        oMemBe,
   output logic [DATA_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemWdata,
   input  logic [DATA_W-1:0] iMemRdata,
   output logic              oBusy,
   output logic              oGntId
);

   localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

   state_e              state_q;
   logic                last_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                we_q;
   logic [DATA_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [3:0]          be_q;
   logic                gnt_q;
   logic                mem_re_q;
   logic                mem_we_q;
   logic                ack0_q;
   logic                ack1_q;
   logic [DATA_W-1:0]   rdata0_q;
   logic [DATA_W-1:0]   rdata1_q;

   logic                winner_d;
   logic                fixed_prio;

   assign fixed_prio = (CPU_PRIORITY != 0);

   arb_rr_pick u_pick (
      .req        ({iReq1, iReq0}),
      .last       (last_q),
      .fixed_prio (fixed_prio),
      .winner     (winner_d)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q  <= IDLE;
         last_q   <= PORT_AUX;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         gnt_q    <= PORT_CPU;
         mem_re_q <= 1'b0;
         mem_we_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
               if (iReq0 || iReq1) begin
                  // Strobes are raised here so they are registered for the first ACCESS cycle.
                  if (winner_d == PORT_AUX) begin
                     we_q     <= iWe1;
                     addr_q   <= iAddr1;
                     wdata_q  <= iWdata1;
                     be_q     <= iBe1;
                     mem_re_q <= ~iWe1;
                     mem_we_q <= iWe1;
                  end else begin
                     we_q     <= iWe0;
                     addr_q   <= iAddr0;
                     wdata_q  <= iWdata0;
                     be_q     <= iBe0;
                     mem_re_q <= ~iWe0;
                     mem_we_q <= iWe0;
                  end
                  gnt_q   <= winner_d;
                  last_q  <= winner_d;
                  cnt_q   <= CNT_W'(WAIT_STATES);
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  mem_re_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if (gnt_q == PORT_AUX) begin
                     ack1_q <= 1'b1;
                     if (!we_q) rdata1_q <= iMemRdata;
                  end else begin
                     ack0_q <= 1'b1;
                     if (!we_q) rdata0_q <= iMemRdata;
                  end
                  state_q <= RESP;
               end
            end
            RESP: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign oAck0     = ack0_q;
   assign oAck1     = ack1_q;
   assign oRdata0   = rdata0_q;
   assign oRdata1   = rdata1_q;
   assign oMemRe    = mem_re_q;
   assign oMemWe    = mem_we_q;
   assign oMemBe    = be_q;
   assign oMemAddr  = addr_q;
   assign oMemWdata = wdata_q;
   assign oBusy     = (state_q != IDLE);
   assign oGntId    = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: three arbiter builds (RR/1 wait, fixed prio/1 wait,
// RR/0 wait) share one stimulus bus; each scenario checks the relevant build.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
   logic [3:0]  be0, be1;

   logic        ack0_a, ack1_a, mre_a, mwe_a, busy_a, gnt_a;
   logic [31:0] rdata0_a, rdata1_a, maddr_a, mwdata_a;
   logic [3:0]  mbe_a;
   logic        ack0_b, ack1_b, mre_b, mwe_b, busy_b, gnt_b;
   logic [31:0] rdata0_b, rdata1_b, maddr_b, mwdata_b;
   logic [3:0]  mbe_b;
   logic        ack0_c, ack1_c, mre_c, mwe_c, busy_c, gnt_c;
   logic [31:0] rdata0_c, rdata1_c, maddr_c, mwdata_c;
   logic [3:0]  mbe_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.WAIT_STATES(1), .CPU_PRIORITY(0), .DATA_W(32)) dut_a (
      .iCLK(clk), .iRST(rst), .iReq0(req0), .iReq1(req1), .iWe0(we0), .iWe1(we1),
      .iAddr0(addr0), .iAddr1(addr1), .iWdata0(wdata0), .iWdata1(wdata1),
      .iBe0(be0), .iBe1(be1), .oAck0(ack0_a), .oAck1(ack1_a),
      .oRdata0(rdata0_a), .oRdata1(rdata1_a), .oMemRe(mre_a), .oMemWe(mwe_a),
      .oMemBe(mbe_a), .oMemAddr(maddr_a), .oMemWdata(mwdata_a),
      .iMemRdata(mem_rdata), .oBusy(busy_a), .oGntId(gnt_a)
   );

   mem_bus_arbiter #(.WAIT_STATES(1), .CPU_PRIORITY(1), .DATA_W(32)) dut_b (
      .iCLK(clk), .iRST(rst), .iReq0(req0), .iReq1(req1), .iWe0(we0), .iWe1(we1),
      .iAddr0(addr0), .iAddr1(addr1), .iWdata0(wdata0), .iWdata1(wdata1),
      .iBe0(be0), .iBe1(be1), .oAck0(ack0_b), .oAck1(ack1_b),
      .oRdata0(rdata0_b), .oRdata1(rdata1_b), .oMemRe(mre_b), .oMemWe(mwe_b),
      .oMemBe(mbe_b), .oMemAddr(maddr_b), .oMemWdata(mwdata_b),
      .iMemRdata(mem_rdata), .oBusy(busy_b), .oGntId(gnt_b)
   );

   mem_bus_arbiter #(.WAIT_STATES(0), .CPU_PRIORITY(0), .DATA_W(32)) dut_c (
      .iCLK(clk), .iRST(rst), .iReq0(req0), .iReq1(req1), .iWe0(we0), .iWe1(we1),
      .iAddr0(addr0), .iAddr1(addr1), .iWdata0(wdata0), .iWdata1(wdata1),
      .iBe0(be0), .iBe1(be1), .oAck0(ack0_c), .oAck1(ack1_c),
      .oRdata0(rdata0_c), .oRdata1(rdata1_c), .oMemRe(mre_c), .oMemWe(mwe_c),
      .oMemBe(mbe_c), .oMemAddr(maddr_c), .oMemWdata(mwdata_c),
      .iMemRdata(mem_rdata), .oBusy(busy_c), .oGntId(gnt_c)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      be0 = 4'hF; be1 = 4'hF; mem_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] words [3];
      words[0] = 32'hA5A5_0001;
      words[1] = 32'h1234_5678;
      words[2] = 32'hCAFE_F00D;

      // Reset then idle
      do_reset();
      chk("rst_busy",   64'(busy_a), 64'd0);
      chk("rst_strobe", 64'({ack0_a, ack1_a, mre_a, mwe_a, gnt_a}), 64'd0);
      chk("rst_bus",    64'({mbe_a, maddr_a}), 64'd0);
      chk("rst_wdata",  64'(mwdata_a), 64'd0);
      chk("rst_rdata",  {rdata0_a, rdata1_a}, 64'd0);
      tick();
      chk("idle_busy",  64'(busy_a), 64'd0);

      // Single read, one wait state
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1001_0004; mem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("rd_acc1_re",   64'({mre_a, mwe_a, busy_a}), 64'b101);
      chk("rd_acc1_addr", 64'(maddr_a), 64'h1001_0004);
      chk("rd_acc1_ack",  64'(ack0_a), 64'd0);
      tick();
      chk("rd_acc2_re",   64'(mre_a), 64'd1);
      chk("rd_acc2_ack",  64'(ack0_a), 64'd0);
      tick();
      chk("rd_resp_ack",  64'({ack0_a, ack1_a, mre_a}), 64'b100);
      chk("rd_rdata0",    64'(rdata0_a), 64'hDEAD_BEEF);
      req0 = 1'b0;
      tick();
      chk("rd_done",      64'({ack0_a, busy_a}), 64'd0);

      // Conflict under round-robin
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h1111_1111;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h2222_2222;
      tick();
      chk("rr_g0",       64'({gnt_a, mwe_a, mre_a}), 64'b010);
      chk("rr_g0_bus",   {maddr_a, mwdata_a}, {32'h0, 32'h1111_1111});
      tick();
      chk("rr_g0_noack", 64'({ack0_a, ack1_a}), 64'd0);
      tick();
      chk("rr_ack0",     64'({ack0_a, ack1_a, mwe_a}), 64'b100);
      tick();
      chk("rr_idle",     64'({ack0_a, ack1_a, busy_a}), 64'd0);
      tick();
      chk("rr_g1",       64'({gnt_a, mwe_a}), 64'b11);
      chk("rr_g1_bus",   {maddr_a, mwdata_a}, {32'h4, 32'h2222_2222});
      tick();
      tick();
      chk("rr_ack1",     64'({ack0_a, ack1_a}), 64'b01);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("rr_ack1_end", 64'({ack0_a, ack1_a}), 64'd0);
      tick();
      chk("rr_quiet",    64'(busy_a), 64'd0);
      chk("rr_wr_rdata", {rdata0_a, rdata1_a}, 64'd0);

      // Fixed CPU priority
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200;
      mem_rdata = 32'h0BAD_CAFE;
      tick();
      chk("fp_g0a",     64'(gnt_b), 64'd0);
      tick(); tick();
      chk("fp_ack0a",   64'({ack0_b, ack1_b}), 64'b10);
      tick(); tick();
      chk("fp_g0b",     64'({gnt_b, maddr_b}), {1'b0, 32'h100});
      tick(); tick();
      chk("fp_ack0b",   64'({ack0_b, ack1_b}), 64'b10);
      req0 = 1'b0;
      tick(); tick();
      chk("fp_g1",      64'({gnt_b, maddr_b}), {1'b1, 32'h200});
      tick(); tick();
      chk("fp_ack1",    64'({ack0_b, ack1_b}), 64'b01);
      chk("fp_rdata1",  64'(rdata1_b), 64'h0BAD_CAFE);
      req1 = 1'b0;

      // Zero wait states, back-to-back reads on port 1
      do_reset();
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20; be1 = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         mem_rdata = words[i];
         tick();
         chk("zw_access", 64'({mre_c, mbe_c, gnt_c, ack1_c}), {1'b1, 4'b0011, 1'b1, 1'b0});
         tick();
         chk("zw_ack",    64'({ack1_c, ack0_c}), 64'b10);
         chk("zw_rdata1", 64'(rdata1_c), 64'(words[i]));
         tick();
         chk("zw_idle",   64'({ack1_c, busy_c}), 64'd0);
      end
      req1 = 1'b0;

      // Reset during a write access
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; mem_rdata = 32'h5A5A_5A5A;
      tick(); tick(); tick();
      chk("mr_rd_rdata0", 64'(rdata0_a), 64'h5A5A_5A5A);
      we0 = 1'b1; wdata0 = 32'h0000_0033;
      tick();
      tick();
      chk("mr_we_on",     64'({mwe_a, busy_a}), 64'b11);
      rst = 1'b1;
      tick();
      chk("mr_we_off",    64'({mwe_a, ack0_a, busy_a}), 64'd0);
      chk("mr_rdata",     {rdata0_a, rdata1_a}, 64'd0);
      req0 = 1'b0; rst = 1'b0;
      tick(); tick(); tick();
      chk("mr_no_ack",    64'({ack0_a, ack1_a, busy_a}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
